// File: rtl/req_enc_pkg.sv
// Shared constants and FSM encoding for the 32-source request encoder.
package req_enc_pkg;

  localparam int unsigned N_REQ = 32;
  localparam int unsigned IDX_W = 5;
  localparam logic [N_REQ-1:0] ALL_IDLE_N = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/find_first32.sv
// Combinational search for the first set bit at or after 'start', wrapping 31 -> 0.
module find_first32
  import req_enc_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      // Index arithmetic wraps naturally at IDX_W bits.
      pos = start + IDX_W'(i);
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/req_encoder32_5.sv
// Sticky active-low request collector emitting one 5-bit index per valid/ready handshake.
// Define REQ_ENC_RR_EN for round-robin selection; otherwise lowest index wins.
module req_encoder32_5
  import req_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             flush,
  input  logic [N_REQ-1:0] req_n,
  output logic [IDX_W-1:0] code,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [N_REQ-1:0] pend_n,
  output logic             any_pend
);

  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] code_q, code_d;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             grant;

`ifdef REQ_ENC_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;

  assign start = rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (grant) begin
      rr_ptr_q <= sel_idx + IDX_W'(1);
    end
  end
`else
  assign start = '0;
`endif

  // Selection looks only at registered pending, never at this edge's captures.
  find_first32 u_find (
    .vec   (pending_q),
    .start (start),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pending_d = pending_q;
    grant     = 1'b0;

    if (state_q == ST_IDLE || code_ready) begin
      if (sel_found) begin
        grant              = 1'b1;
        code_d             = sel_idx;
        state_d            = ST_HOLD;
        pending_d[sel_idx] = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Capture after clear so a simultaneous set of the granted bit wins.
    if (ena) begin
      pending_d = pending_d | ~req_n;
    end

    if (flush) begin
      pending_d = '0;
      state_d   = ST_IDLE;
      code_d    = '0;
      grant     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      code_q    <= '0;
      state_q   <= ST_IDLE;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
      state_q   <= state_d;
    end
  end

  assign code       = code_q;
  assign code_valid = (state_q == ST_HOLD);
  assign pend_n     = ALL_IDLE_N ^ pending_q;
  assign any_pend   = |pending_q;

endmodule
